mem_arbiter: RTL and testbench

Initiator side of the main-memory port: accepts line-fill requests from the I-cache and D-cache plus dirty-line write-backs from the D-cache, and serializes them onto the single `memory` request interface. Reads are issued as one-cycle `req` pulses and completed when `response_valid` returns after the fixed transfer latency. Write-backs are broken into word stores. Sits between the L1 caches and `memory` in the top level.

---
 rtl/brisc_pkg.sv | 17 +
 rtl/mem_rr_arb.sv | 34 +++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared types and line geometry for the L1-to-memory path.
package brisc_pkg;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    WB,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } mem_arb_state_e;

  localparam int LINE_BYTES       = 16;
  localparam int WORDS_PER_LINE   = 4;
  localparam int LINE_OFFSET_BITS = 4;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin between I-cache (bit 0) and D-cache (bit 1); grant is combinational.
// The last-granted pointer moves only when the owner commits a grant via advance.
module mem_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_dc_q;
  logic last_dc_d;

  always_comb begin
    grant     = req;
    last_dc_d = last_dc_q;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      grant = last_dc_q ? 2'b01 : 2'b10;
    end
    if (advance && (grant != 2'b00)) begin
      last_dc_d = grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_dc_q <= 1'b0;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I/D line fills and D-cache write-backs onto the single memory port.
// Reads: mem_req 1 cycle after grant, fill_valid DATA_TRANSFER_TIME+2 after; write-backs: 4 store beats.
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int FILL_DATA_WIDTH    = 128,
  parameter int WORD_WIDTH         = 32,
  parameter int DATA_TRANSFER_TIME = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req,
  input  logic [ADDRESS_WIDTH-1:0]   ic_addr,
  output logic                       ic_fill_valid,
  input  logic                       dc_req,
  input  logic [ADDRESS_WIDTH-1:0]   dc_addr,
  output logic                       dc_fill_valid,
  output logic [FILL_DATA_WIDTH-1:0] fill_data,
  input  logic                       dc_evict,
  input  logic [ADDRESS_WIDTH-1:0]   dc_evict_addr,
  input  logic [FILL_DATA_WIDTH-1:0] dc_evict_data,
  output logic                       dc_evict_done,
  output logic                       mem_req,
  output logic                       mem_store,
  output logic                       mem_store_word,
  output logic [ADDRESS_WIDTH-1:0]   mem_address,
  output logic [WORD_WIDTH-1:0]      mem_evict_data,
  input  logic [FILL_DATA_WIDTH-1:0] mem_fill_data,
  input  logic                       mem_response_valid,
  output logic                       err_unexpected_resp
);

  localparam int DCW = $clog2(DATA_TRANSFER_TIME + 2);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DATA_TRANSFER_TIME);

  mem_arb_state_e state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           sel_dc_q, sel_dc_d;

  logic                       mem_req_q, mem_req_d;
  logic                       mem_store_q, mem_store_d;
  logic                       mem_store_word_q, mem_store_word_d;
  logic [ADDRESS_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [WORD_WIDTH-1:0]      mem_evict_data_q, mem_evict_data_d;
  logic                       ic_fill_valid_q, ic_fill_valid_d;
  logic                       dc_fill_valid_q, dc_fill_valid_d;
  logic [FILL_DATA_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                       dc_evict_done_q, dc_evict_done_d;
  logic                       err_q, err_d;

  logic [1:0]                                grant;
  logic                                      arb_advance;
  logic [ADDRESS_WIDTH-1:0]                  rd_addr;
  logic [ADDRESS_WIDTH-1:0]                  wb_base;
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] evict_words;

  assign rd_addr     = grant[1] ? dc_addr : ic_addr;
  assign wb_base     = {dc_evict_addr[ADDRESS_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  assign evict_words = dc_evict_data;

  mem_rr_arb u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({dc_req, ic_req}),
    .advance (arb_advance),
    .grant   (grant)
  );

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    drain_cnt_d      = drain_cnt_q;
    sel_dc_d         = sel_dc_q;
    arb_advance      = 1'b0;
    mem_req_d        = 1'b0;
    mem_store_d      = 1'b0;
    mem_store_word_d = 1'b0;
    mem_address_d    = '0;
    mem_evict_data_d = '0;
    ic_fill_valid_d  = 1'b0;
    dc_fill_valid_d  = 1'b0;
    dc_evict_done_d  = 1'b0;
    fill_data_d      = fill_data_q;
    err_d            = err_q | (mem_response_valid && (state_q != RD_WAIT) && (state_q != DRAIN));

    case (state_q)
      // Memory's delay line is not reset, so stale responses are swallowed here.
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      IDLE: begin
        if (dc_evict) begin
          state_d = WB;
          beat_d  = 2'd0;
        end else if (grant != 2'b00) begin
          arb_advance   = 1'b1;
          sel_dc_d      = grant[1];
          state_d       = RD_ISSUE;
          mem_req_d     = 1'b1;
          mem_address_d = {rd_addr[ADDRESS_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
        end
      end
      WB: begin
        if (beat_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_response_valid) begin
          fill_data_d     = mem_fill_data;
          state_d         = RESP;
          dc_fill_valid_d = sel_dc_q;
          ic_fill_valid_d = !sel_dc_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = DRAIN;
    endcase

    // Store beat outputs are registered, so they follow the beat being entered.
    if (state_d == WB) begin
      mem_req_d        = 1'b1;
      mem_store_d      = 1'b1;
      mem_store_word_d = 1'b1;
      mem_address_d    = wb_base + ADDRESS_WIDTH'({beat_d, 2'b00});
      mem_evict_data_d = evict_words[beat_d];
      dc_evict_done_d  = (beat_d == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= DRAIN;
      beat_q           <= '0;
      drain_cnt_q      <= '0;
      sel_dc_q         <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_store_q      <= 1'b0;
      mem_store_word_q <= 1'b0;
      mem_address_q    <= '0;
      mem_evict_data_q <= '0;
      ic_fill_valid_q  <= 1'b0;
      dc_fill_valid_q  <= 1'b0;
      fill_data_q      <= '0;
      dc_evict_done_q  <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      drain_cnt_q      <= drain_cnt_d;
      sel_dc_q         <= sel_dc_d;
      mem_req_q        <= mem_req_d;
      mem_store_q      <= mem_store_d;
      mem_store_word_q <= mem_store_word_d;
      mem_address_q    <= mem_address_d;
      mem_evict_data_q <= mem_evict_data_d;
      ic_fill_valid_q  <= ic_fill_valid_d;
      dc_fill_valid_q  <= dc_fill_valid_d;
      fill_data_q      <= fill_data_d;
      dc_evict_done_q  <= dc_evict_done_d;
      err_q            <= err_d;
    end
  end

  assign mem_req             = mem_req_q;
  assign mem_store           = mem_store_q;
  assign mem_store_word      = mem_store_word_q;
  assign mem_address         = mem_address_q;
  assign mem_evict_data      = mem_evict_data_q;
  assign ic_fill_valid       = ic_fill_valid_q;
  assign dc_fill_valid       = dc_fill_valid_q;
  assign fill_data           = fill_data_q;
  assign dc_evict_done       = dc_evict_done_q;
  assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small fixed-latency memory model that is never reset.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int FW  = 128;
  localparam int WW  = 32;
  localparam int DTT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_evict;
  logic [AW-1:0] ic_addr, dc_addr, dc_evict_addr;
  logic [FW-1:0] dc_evict_data;
  logic          ic_fill_valid, dc_fill_valid, dc_evict_done;
  logic [FW-1:0] fill_data;
  logic          mem_req, mem_store, mem_store_word;
  logic [AW-1:0] mem_address;
  logic [WW-1:0] mem_evict_data;
  logic [FW-1:0] mem_fill_data;
  logic          mem_response_valid;
  logic          err_unexpected_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDRESS_WIDTH      (AW),
    .FILL_DATA_WIDTH    (FW),
    .WORD_WIDTH         (WW),
    .DATA_TRANSFER_TIME (DTT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ic_req              (ic_req),
    .ic_addr             (ic_addr),
    .ic_fill_valid       (ic_fill_valid),
    .dc_req              (dc_req),
    .dc_addr             (dc_addr),
    .dc_fill_valid       (dc_fill_valid),
    .fill_data           (fill_data),
    .dc_evict            (dc_evict),
    .dc_evict_addr       (dc_evict_addr),
    .dc_evict_data       (dc_evict_data),
    .dc_evict_done       (dc_evict_done),
    .mem_req             (mem_req),
    .mem_store           (mem_store),
    .mem_store_word      (mem_store_word),
    .mem_address         (mem_address),
    .mem_evict_data      (mem_evict_data),
    .mem_fill_data       (mem_fill_data),
    .mem_response_valid  (mem_response_valid),
    .err_unexpected_resp (err_unexpected_resp)
  );

  // Memory model: unwritten word i reads as 0xA0000000+i; responses DTT cycles after a read req.
  bit [31:0]    mem_words   [0:255];
  bit           mem_written [0:255];
  bit [DTT-1:0] pipe_v;
  bit [AW-1:0]  pipe_a [0:DTT-1];
  bit           force_resp;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[DTT-2:0], (mem_req === 1'b1) && (mem_store === 1'b0)};
    pipe_a[0] <= mem_address;
    for (int i = 1; i < DTT; i++) pipe_a[i] <= pipe_a[i-1];
    if (mem_req === 1'b1 && mem_store === 1'b1 && mem_store_word === 1'b1) begin
      mem_words[mem_address[9:2]]   <= mem_evict_data;
      mem_written[mem_address[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    logic [7:0] idx;
    idx           = '0;
    mem_fill_data = '0;
    if (pipe_v[DTT-1]) begin
      for (int j = 0; j < 4; j++) begin
        idx = {pipe_a[DTT-1][9:4], 2'(j)};
        mem_fill_data[32*j +: 32] = mem_written[idx] ? mem_words[idx] : 32'hA000_0000 + 32'(idx);
      end
    end
  end

  assign mem_response_valid = pipe_v[DTT-1] | force_resp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_req"},        mem_req, 0);
    chk({tag, "_mem_store"},      mem_store, 0);
    chk({tag, "_mem_store_word"}, mem_store_word, 0);
    chk({tag, "_mem_address"},    mem_address, 0);
    chk({tag, "_mem_evict_data"}, mem_evict_data, 0);
    chk({tag, "_ic_fill_valid"},  ic_fill_valid, 0);
    chk({tag, "_dc_fill_valid"},  dc_fill_valid, 0);
    chk({tag, "_fill_data"},      fill_data, 0);
    chk({tag, "_dc_evict_done"},  dc_evict_done, 0);
    chk({tag, "_err"},            err_unexpected_resp, 0);
  endtask

  // One-clock reset pulse; returns at the negedge where reset is released.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_evict = 1'b0;
    @(negedge clk);
    chk_outputs_zero(tag);
    reset = 1'b1;
  endtask

  // Read from a single requester; req_off is the expected negedge index of the mem_req beat.
  task automatic run_read(input bit is_dc, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                          input logic [FW-1:0] exp_line, input int req_off, input string tag);
    int            req_k = 0;
    int            fv_k  = 0;
    int            n_req = 0;
    bit            other_fv = 1'b0;
    logic          st_seen = 1'b0;
    logic [AW-1:0] a_seen = '0;
    logic [FW-1:0] d_seen = '0;
    @(negedge clk);
    if (is_dc) begin dc_req = 1'b1; dc_addr = addr; end
    else       begin ic_req = 1'b1; ic_addr = addr; end
    for (int k = 1; k <= req_off + 10; k++) begin
      @(negedge clk);
      if (mem_req) begin
        n_req++;
        if (req_k == 0) begin req_k = k; a_seen = mem_address; st_seen = mem_store; end
      end
      if (is_dc ? ic_fill_valid : dc_fill_valid) other_fv = 1'b1;
      if (is_dc ? dc_fill_valid : ic_fill_valid) begin
        fv_k = k; d_seen = fill_data;
        break;
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    chk({tag, "_req_cycle"},  req_k, req_off);
    chk({tag, "_req_count"},  n_req, 1);
    chk({tag, "_req_store"},  st_seen, 0);
    chk({tag, "_req_addr"},   a_seen, exp_addr);
    chk({tag, "_fill_cycle"}, fv_k, req_off + 6);
    chk({tag, "_fill_data"},  d_seen, exp_line);
    chk({tag, "_other_fv"},   other_fv, 0);
  endtask

  // Write-back; with_rd also holds a D-cache read that must follow the last beat.
  task automatic run_wb(input logic [AW-1:0] addr, input logic [FW-1:0] line, input logic [AW-1:0] base,
                        input bit with_rd, input logic [AW-1:0] rd_addr, input string tag);
    logic [31:0] w;
    @(negedge clk);
    dc_evict = 1'b1; dc_evict_addr = addr; dc_evict_data = line;
    if (with_rd) begin dc_req = 1'b1; dc_addr = rd_addr; end
    for (int k = 1; k <= (with_rd ? 12 : 5); k++) begin
      @(negedge clk);
      if (k <= 4) begin
        w = line[32*(k-1) +: 32];
        chk($sformatf("%s_beat%0d_ctl", tag, k-1),  {mem_req, mem_store, mem_store_word}, 3'b111);
        chk($sformatf("%s_beat%0d_addr", tag, k-1), mem_address, base + 32'(4*(k-1)));
        chk($sformatf("%s_beat%0d_data", tag, k-1), mem_evict_data, w);
        chk($sformatf("%s_beat%0d_done", tag, k-1), dc_evict_done, (k == 4));
        if (k == 4) dc_evict = 1'b0;
      end else if (k == 5) begin
        chk({tag, "_after_req"},  mem_req, 0);
        chk({tag, "_after_done"}, dc_evict_done, 0);
      end else if (k == 6) begin
        chk({tag, "_rd_req"},  {mem_req, mem_store}, 2'b10);
        chk({tag, "_rd_addr"}, mem_address, base);
      end else if (k == 12) begin
        chk({tag, "_rd_fill_valid"}, dc_fill_valid, 1);
        chk({tag, "_rd_fill_data"},  fill_data, line);
        dc_req = 1'b0;
      end
    end
  endtask

  typedef struct {
    bit            is_dc;
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_addr;
    logic [FW-1:0] exp_line;
  } rd_vec_t;

  rd_vec_t vecs [4];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] wb_line, wb_line2, d_seen;
    bit            exp_dc [4];
    bit            got_dc;
    bit            raise_ic, raise_dc, any_bad;
    int            n_pulse;

    vecs[0] = '{1'b0, 32'h0000_0047, 32'h0000_0040, 128'hA0000013_A0000012_A0000011_A0000010};
    vecs[1] = '{1'b1, 32'h0000_013C, 32'h0000_0130, 128'hA000004F_A000004E_A000004D_A000004C};
    vecs[2] = '{1'b0, 32'h0000_03F8, 32'h0000_03F0, 128'hA00000FF_A00000FE_A00000FD_A00000FC};
    vecs[3] = '{1'b1, 32'h0000_0209, 32'h0000_0200, 128'hA0000083_A0000082_A0000081_A0000080};
    wb_line  = 128'h3DCCBBAA_2DCCBBAA_1DCCBBAA_DDCCBBAA;
    wb_line2 = 128'h44332211_88776655_CCBBAA99_00FFEEDD;
    exp_dc[0] = 1'b1; exp_dc[1] = 1'b0; exp_dc[2] = 1'b1; exp_dc[3] = 1'b0;

    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_evict = 1'b0; force_resp = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_evict_addr = '0; dc_evict_data = '0;

    // Reset state, then a read held from reset release must wait out the drain window.
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b1;
    run_read(1'b0, 32'h0000_0047, 32'h0000_0040, vecs[0].exp_line, 6, "drain_read");

    for (int i = 0; i < 4; i++) begin
      run_read(vecs[i].is_dc, vecs[i].addr, vecs[i].exp_addr, vecs[i].exp_line, 1, $sformatf("vec%0d", i));
    end

    run_wb(32'h0000_0080, wb_line, 32'h0000_0080, 1'b0, '0, "wb");
    run_read(1'b1, 32'h0000_0080, 32'h0000_0080, wb_line, 1, "wb_readback");

    run_wb(32'h0000_00C0, wb_line2, 32'h0000_00C0, 1'b1, 32'h0000_00C4, "wb_then_rd");

    // Reset while a read is in flight: its response lands in DRAIN and must vanish.
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h0000_0047;
    @(negedge clk);
    chk("midrst_req", mem_req, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    any_bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ic_fill_valid || dc_fill_valid || mem_req || err_unexpected_resp) any_bad = 1'b1;
    end
    chk("midrst_quiet", any_bad, 0);
    chk("midrst_err", err_unexpected_resp, 0);
    run_read(vecs[2].is_dc, vecs[2].addr, vecs[2].exp_addr, vecs[2].exp_line, 1, "post_reset_read");

    // Stray response in IDLE sets the sticky error; only reset clears it.
    @(negedge clk);
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    chk("err_set", err_unexpected_resp, 1);
    repeat (4) @(negedge clk);
    chk("err_sticky", err_unexpected_resp, 1);
    run_read(vecs[1].is_dc, vecs[1].addr, vecs[1].exp_addr, vecs[1].exp_line, 1, "err_read");
    chk("err_after_read", err_unexpected_resp, 1);
    do_reset("err_reset");
    repeat (8) @(negedge clk);
    chk("err_cleared", err_unexpected_resp, 0);

    // Both caches held: round-robin from reset gives D, I, D, I with no bubble.
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h0000_0100;
    dc_req = 1'b1; dc_addr = 32'h0000_02C0;
    raise_ic = 1'b0; raise_dc = 1'b0; n_pulse = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (raise_ic) begin ic_req = 1'b1; raise_ic = 1'b0; end
      if (raise_dc) begin dc_req = 1'b1; raise_dc = 1'b0; end
      if (ic_fill_valid || dc_fill_valid) begin
        got_dc = dc_fill_valid;
        d_seen = fill_data;
        chk($sformatf("arb_order%0d", n_pulse), got_dc, exp_dc[n_pulse]);
        chk($sformatf("arb_time%0d", n_pulse), k, 7 + 8 * n_pulse);
        chk($sformatf("arb_data%0d", n_pulse), d_seen,
            got_dc ? 128'hA00000B3_A00000B2_A00000B1_A00000B0
                   : 128'hA0000043_A0000042_A0000041_A0000040);
        if (got_dc) begin dc_req = 1'b0; raise_dc = 1'b1; end
        else        begin ic_req = 1'b0; raise_ic = 1'b1; end
        n_pulse++;
        if (n_pulse == 4) begin
          ic_req = 1'b0; dc_req = 1'b0;
          break;
        end
      end
    end
    chk("arb_pulses", n_pulse, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
